// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC sequencer feeding a one-entry fetch slot toward decode
// Halts in FAULT on a misaligned or out-of-range fetch; only reset leaves FAULT.
module fetch_sequencer #(
  parameter int unsigned MEM_BYTES = 512,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] instructionAddress,
  input  logic [31:0] instructionIn,
  output logic [31:0] instOut,
  output logic [31:0] instPc,
  output logic        instValid,
  input  logic        instReady,
  input  logic        redirectValid,
  input  logic [31:0] redirectTarget,
  output logic        halted,
  output logic [31:0] faultAddr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [32:0] LAST_BYTE = 33'(MEM_BYTES) - 33'd1;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_out_q, inst_out_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic        slot_free;
  logic        pc_in_range;
  logic        target_ok;

  // Widened to 33 bits so addresses near 2^32 cannot wrap back into range.
  function automatic logic word_in_range(input logic [31:0] addr);
    return ({1'b0, addr} + 33'd3) <= LAST_BYTE;
  endfunction

  assign slot_free   = !inst_valid_q || instReady;
  assign pc_in_range = word_in_range(pc_q);
  assign target_ok   = (redirectTarget[1:0] == 2'b00) && word_in_range(redirectTarget);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_out_d   = inst_out_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    fault_addr_d = fault_addr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = RESET_PC;
        end
      end
      FETCH: begin
        if (redirectValid) begin
          // Redirect flushes the slot, whether it was held or being accepted now.
          inst_valid_d = 1'b0;
          if (target_ok) begin
            pc_d = redirectTarget;
          end else begin
            state_d      = FAULT;
            fault_addr_d = redirectTarget;
          end
        end else if (slot_free) begin
          if (pc_in_range) begin
            inst_out_d   = instructionIn;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + 32'd4;
          end else begin
            state_d      = FAULT;
            fault_addr_d = pc_q;
            inst_valid_d = 1'b0;
          end
        end
      end
      FAULT: begin
        inst_valid_d = 1'b0;
      end
      default: begin
        state_d      = IDLE;
        inst_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      inst_out_q   <= 32'd0;
      inst_pc_q    <= 32'd0;
      inst_valid_q <= 1'b0;
      fault_addr_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_out_q   <= inst_out_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign instructionAddress = (state_q == FETCH) ? pc_q : 32'd0;
  assign instOut            = inst_out_q;
  assign instPc             = inst_pc_q;
  assign instValid          = inst_valid_q;
  assign halted             = (state_q == FAULT);
  assign faultAddr          = fault_addr_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] instructionAddress;
  logic [31:0] instructionIn;
  logic [31:0] instOut;
  logic [31:0] instPc;
  logic        instValid;
  logic        instReady;
  logic        redirectValid;
  logic [31:0] redirectTarget;
  logic        halted;
  logic [31:0] faultAddr;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q [$];
  logic [7:0]  mem [0:511];
  logic [8:0]  ia;

  fetch_sequencer dut (
    .clock(clock), .reset(reset), .start(start),
    .instructionAddress(instructionAddress), .instructionIn(instructionIn),
    .instOut(instOut), .instPc(instPc), .instValid(instValid), .instReady(instReady),
    .redirectValid(redirectValid), .redirectTarget(redirectTarget),
    .halted(halted), .faultAddr(faultAddr)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h0100_4020;
      32'd4:   return 32'h0100_4020;
      32'd8:   return 32'h0100_4022;
      32'd12:  return 32'h2108_0008;
      default: return 32'hC0DE_0000 | a;
    endcase
  endfunction

  assign ia = instructionAddress[8:0];
  always_comb begin
    instructionIn = 32'd0;
    if (instructionAddress <= 32'd508)
      instructionIn = {mem[ia], mem[ia + 9'd1], mem[ia + 9'd2], mem[ia + 9'd3]};
  end

  // Every handshake must match the oldest expected (pc, word) pair.
  always @(negedge clock) begin
    if (!reset && instValid && instReady) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_delivery: got pc %h word %h, required none", instPc, instOut);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({instPc, instOut} !== e) begin
          fails++;
          $display("FAIL delivery: got pc %h word %h, required pc %h word %h",
                   instPc, instOut, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_q.push_back({a, exp_word(a)});
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; instReady = 1'b0;
    redirectValid = 1'b0; redirectTarget = 32'd0;
    tick; tick;
    @(negedge clock);
    tests++;
    if ({instValid, halted} !== 2'b00) begin
      fails++; $display("FAIL reset_flags: got valid/halted %b%b, required 00", instValid, halted);
    end
    tests++;
    if (instOut !== 32'd0 || instPc !== 32'd0) begin
      fails++; $display("FAIL reset_slot: got out %h pc %h, required 0 0", instOut, instPc);
    end
    tests++;
    if (faultAddr !== 32'd0 || instructionAddress !== 32'd0) begin
      fails++; $display("FAIL reset_addr: got fault %h addr %h, required 0 0", faultAddr, instructionAddress);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      redirectValid = i[0]; redirectTarget = 32'h40; instReady = 1'b1;
      @(negedge clock);
      tests++;
      if ({instValid, halted} !== 2'b00 || instructionAddress !== 32'd0) begin
        fails++;
        $display("FAIL idle_hold: got valid %b halted %b addr %h, required 0 0 0",
                 instValid, halted, instructionAddress);
      end
    end
    redirectValid = 1'b0;
  endtask

  task automatic test_streaming;
    int n;
    tick;
    start = 1'b1; instReady = 1'b1;
    push_exp(32'd0); push_exp(32'd4); push_exp(32'd8); push_exp(32'd12);
    tick;
    start = 1'b0;
    n = 0;
    @(negedge clock);
    while (!instValid && n < 10) begin
      @(negedge clock); n++;
    end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clock);
      tests++;
      if (instValid !== 1'b1) begin
        fails++; $display("FAIL stream_valid[%0d]: got %b, required 1", k, instValid);
      end
    end
    #2;
    reset = 1'b1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL stream_drain: got %0d pending, required 0", exp_q.size());
    end
    tick;
    reset = 1'b0;
  endtask

  task automatic test_backpressure_redirect;
    int n;
    tick;
    start = 1'b1; instReady = 1'b1;
    push_exp(32'd0); push_exp(32'd4); push_exp(32'd8); push_exp(32'h1B8);
    tick;
    start = 1'b0;
    n = 0;
    do begin
      tick; n++;
    end while (!(instValid && instPc == 32'd4) && n < 10);
    tests++;
    if (!(instValid && instPc == 32'd4)) begin
      fails++; $display("FAIL bp_reach: got pc %h valid %b, required pc 4 valid 1", instPc, instValid);
    end
    instReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      tests++;
      if (instValid !== 1'b1 || instPc !== 32'd4 || instOut !== 32'h0100_4020 ||
          instructionAddress !== 32'd8) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got valid %b pc %h out %h addr %h, required 1 4 01004020 8",
                 k, instValid, instPc, instOut, instructionAddress);
      end
      tick;
    end
    instReady = 1'b1;
    tick;
    tests++;
    if (instValid !== 1'b1 || instPc !== 32'd8) begin
      fails++; $display("FAIL bp_resume: got valid %b pc %h, required 1 8", instValid, instPc);
    end
    redirectValid = 1'b1; redirectTarget = 32'h1B8;
    tick;
    redirectValid = 1'b0;
    @(negedge clock);
    tests++;
    if (instValid !== 1'b0) begin
      fails++; $display("FAIL redirect_flush: got valid %b, required 0", instValid);
    end
    tick;
    tests++;
    if (instValid !== 1'b1 || instPc !== 32'h1B8) begin
      fails++; $display("FAIL redirect_target: got valid %b pc %h, required 1 1b8", instValid, instPc);
    end
  endtask

  task automatic test_misaligned;
    redirectValid = 1'b1; redirectTarget = 32'h6;
    tick;
    redirectValid = 1'b0;
    @(negedge clock);
    tests++;
    if (halted !== 1'b1 || faultAddr !== 32'h6 || instValid !== 1'b0 || instructionAddress !== 32'd0) begin
      fails++;
      $display("FAIL misaligned: got halted %b fault %h valid %b addr %h, required 1 6 0 0",
               halted, faultAddr, instValid, instructionAddress);
    end
    tick;
    start = 1'b1; redirectValid = 1'b1; redirectTarget = 32'h20;
    tick;
    start = 1'b0;
    tick; tick;
    @(negedge clock);
    tests++;
    if (halted !== 1'b1 || faultAddr !== 32'h6 || instValid !== 1'b0 || instPc !== 32'h1B8 ||
        instOut !== exp_word(32'h1B8) || instructionAddress !== 32'd0) begin
      fails++;
      $display("FAIL fault_sticky: got halted %b fault %h valid %b pc %h out %h addr %h",
               halted, faultAddr, instValid, instPc, instOut, instructionAddress);
    end
    redirectValid = 1'b0;
  endtask

  task automatic test_overrun;
    int n;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    push_exp(32'h1FC);
    start = 1'b1; instReady = 1'b1;
    tick;
    start = 1'b0; redirectValid = 1'b1; redirectTarget = 32'h1FC;
    tick;
    redirectValid = 1'b0;
    n = 0;
    while (!halted && n < 10) begin
      tick; n++;
    end
    @(negedge clock);
    tests++;
    if (halted !== 1'b1 || faultAddr !== 32'h200 || instValid !== 1'b0) begin
      fails++;
      $display("FAIL overrun: got halted %b fault %h valid %b, required 1 200 0",
               halted, faultAddr, instValid);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL overrun_delivered: got %0d pending, required 0", exp_q.size());
    end
    tick;
    start = 1'b1; redirectValid = 1'b1; redirectTarget = 32'd0;
    tick;
    start = 1'b0;
    tick;
    redirectValid = 1'b0;
    @(negedge clock);
    tests++;
    if (halted !== 1'b1 || faultAddr !== 32'h200 || instructionAddress !== 32'd0 || instValid !== 1'b0) begin
      fails++;
      $display("FAIL overrun_sticky: got halted %b fault %h addr %h valid %b, required 1 200 0 0",
               halted, faultAddr, instructionAddress, instValid);
    end
  endtask

  task automatic test_async_reset;
    int n;
    reset = 1'b1;
    tick;
    reset = 1'b0; instReady = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    n = 0;
    while (!instValid && n < 10) begin
      tick; n++;
    end
    tests++;
    if (instValid !== 1'b1) begin
      fails++; $display("FAIL async_setup: got valid %b, required 1", instValid);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (instValid !== 1'b0 || halted !== 1'b0 || instructionAddress !== 32'd0 || instOut !== 32'd0) begin
      fails++;
      $display("FAIL async_reset: got valid %b halted %b addr %h out %h, required 0 0 0 0",
               instValid, halted, instructionAddress, instOut);
    end
    @(negedge clock);
    reset = 1'b0;
    push_exp(32'd0);
    instReady = 1'b1;
    tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    n = 0;
    @(negedge clock);
    while (!instValid && n < 10) begin
      @(negedge clock); n++;
    end
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL restart: got %0d pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    for (int a = 0; a < 512; a += 4) begin
      logic [31:0] w;
      w = exp_word(32'(a));
      mem[a] = w[31:24]; mem[a+1] = w[23:16]; mem[a+2] = w[15:8]; mem[a+3] = w[7:0];
    end
    test_reset;
    test_streaming;
    test_backpressure_redirect;
    test_misaligned;
    test_overrun;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
